memory_access: RTL



---
 rtl/memory_access.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/memory_access.sv
// Data-memory stage: word/half/byte loads and stores on a local RAM with wait states.
// Define MEM_STAT_EN to add saturating load/store commit counters.
module memory_access #(
    parameter int DEPTH_LOG2  = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ALU_result_in,
    input  logic [31:0] ReadData2_in,
    input  logic        data_mem_en_in,
    input  logic        mem_write_in,
    input  logic [1:0]  mem_size_in,
    input  logic        load_unsigned_in,
    output logic [31:0] mem_data_out,
    output logic        stall_out,
    output logic        done_out,
    output logic        misaligned_out
`ifdef MEM_STAT_EN
    ,
    output logic [15:0] load_count_out,
    output logic [15:0] store_count_out
`endif
);

    localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam int AW = DEPTH_LOG2 + 2;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt;
    logic [AW-1:0]   addr_q;
    logic [31:0]     data_q;
    logic            wr_q, uns_q;
    logic [1:0]      size_q;

    logic [31:0]     mem [2**DEPTH_LOG2];

    logic            misaligned, req_ok, commit;
    logic [DEPTH_LOG2-1:0] idx;
    logic [31:0]     rd_word, rd_shift, ld_val, wdata;
    logic [3:0]      be;
    logic            unused_addr_bits;

    assign unused_addr_bits = ^ALU_result_in[31:AW];

    always_comb begin
        misaligned = 1'b0;
        unique case (1'b1)
            (mem_size_in == 2'b10): misaligned = 1'b0;
            (mem_size_in == 2'b01): misaligned = ALU_result_in[0];
            default:                misaligned = |ALU_result_in[1:0];
        endcase
    end

    assign req_ok = (state == IDLE) && data_mem_en_in && !misaligned;
    assign commit = (state == BUSY) && (cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_ok) state_nxt = BUSY;
            BUSY:    if (cnt == '0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        stall_out = req_ok || (state == BUSY);
        done_out  = (state == DONE);
    end

    // Lane steering for stores and loads, all from the latched request
    assign idx      = addr_q[AW-1:2];
    assign rd_word  = mem[idx];
    assign rd_shift = rd_word >> {addr_q[1:0], 3'b000};

    always_comb begin
        be     = 4'b1111;
        wdata  = data_q;
        ld_val = rd_word;
        unique case (1'b1)
            (size_q == 2'b10): begin
                be     = 4'b0001 << addr_q[1:0];
                wdata  = {4{data_q[7:0]}};
                ld_val = uns_q ? {24'b0, rd_shift[7:0]}
                               : {{24{rd_shift[7]}}, rd_shift[7:0]};
            end
            (size_q == 2'b01): begin
                be     = addr_q[1] ? 4'b1100 : 4'b0011;
                wdata  = {2{data_q[15:0]}};
                ld_val = uns_q ? {16'b0, rd_shift[15:0]}
                               : {{16{rd_shift[15]}}, rd_shift[15:0]};
            end
            default: begin
                be     = 4'b1111;
                wdata  = data_q;
                ld_val = rd_word;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt            <= '0;
            addr_q         <= '0;
            data_q         <= '0;
            wr_q           <= 1'b0;
            size_q         <= 2'b00;
            uns_q          <= 1'b0;
            mem_data_out   <= '0;
            misaligned_out <= 1'b0;
        end else begin
            if (req_ok) begin
                cnt    <= CW'(WAIT_CYCLES);
                addr_q <= ALU_result_in[AW-1:0];
                data_q <= ReadData2_in;
                wr_q   <= mem_write_in;
                size_q <= mem_size_in;
                uns_q  <= load_unsigned_in;
            end else if (state == BUSY && cnt != '0) begin
                cnt <= cnt - CW'(1);
            end
            if (state == IDLE && data_mem_en_in && misaligned)
                misaligned_out <= 1'b1;
            if (commit && !wr_q)
                mem_data_out <= ld_val;
        end
    end

    // RAM contents survive reset; a reset coinciding with commit suppresses the write
    always_ff @(posedge clk) begin
        if (!rst && commit && wr_q) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) mem[idx][b*8 +: 8] <= wdata[b*8 +: 8];
        end
    end

`ifdef MEM_STAT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            load_count_out  <= '0;
            store_count_out <= '0;
        end else if (commit) begin
            if (wr_q && store_count_out != 16'hFFFF)
                store_count_out <= store_count_out + 16'd1;
            if (!wr_q && load_count_out != 16'hFFFF)
                load_count_out <= load_count_out + 16'd1;
        end
    end
`endif

endmodule
